cache_perf_counters: RTL and testbench

- Parametrised per-cache performance counter block; successor to the flat cache perf-counter bundle.
- Sits in each cache instance next to the banks; drives a VX_perf_cache_if master.
- Takes per-bank 1-bit event strobes for 8 event classes and reduces them across NUM_BANKS.
- Accumulates into CTR_BITS counters, with enable/clear control and an atomic snapshot path for CSR readout.

---
 rtl/cache_perf_counters.sv | 109 ++++++++++
 tb/tb_cache_perf_counters.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_perf_counters.sv
// Per-cache event counters: per-bank strobes are reduced, then accumulated over two stages.
// Define CACHE_PERF_SATURATE_EN to make counters saturate instead of wrapping.
module cache_perf_counters #(
  parameter int NUM_BANKS = 4,
  parameter int CTR_BITS  = 44
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    snap,
  input  logic [NUM_BANKS-1:0]    evt_reads,
  input  logic [NUM_BANKS-1:0]    evt_writes,
  input  logic [NUM_BANKS-1:0]    evt_read_misses,
  input  logic [NUM_BANKS-1:0]    evt_write_misses,
  input  logic [NUM_BANKS-1:0]    evt_bank_stalls,
  input  logic [NUM_BANKS-1:0]    evt_mshr_stalls,
  input  logic [NUM_BANKS-1:0]    evt_mem_stalls,
  input  logic [NUM_BANKS-1:0]    evt_crsp_stalls,
  output logic [8*CTR_BITS-1:0]   ctr_out,
  output logic [8*CTR_BITS-1:0]   snap_out,
  output logic                    snap_valid
);

  localparam int INC_BITS = $clog2(NUM_BANKS + 1);
  localparam int NUM_EVT  = 8;
  localparam int SUM_BITS = CTR_BITS + 1;

  logic [NUM_EVT-1:0][NUM_BANKS-1:0] evt;
  logic [NUM_EVT-1:0][INC_BITS-1:0]  inc_d, inc_q;
  logic [NUM_EVT-1:0][CTR_BITS-1:0]  ctr_d, ctr_q;
  logic [NUM_EVT-1:0][CTR_BITS-1:0]  snap_d, snap_q;
  logic                              snap_valid_d, snap_valid_q;

  assign evt[0] = evt_reads;
  assign evt[1] = evt_writes;
  assign evt[2] = evt_read_misses;
  assign evt[3] = evt_write_misses;
  assign evt[4] = evt_bank_stalls;
  assign evt[5] = evt_mshr_stalls;
  assign evt[6] = evt_mem_stalls;
  assign evt[7] = evt_crsp_stalls;

  function automatic logic [INC_BITS-1:0] popcnt(
    input logic [NUM_BANKS-1:0] v
  );
    logic [INC_BITS-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      n = n + INC_BITS'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [CTR_BITS-1:0] ctr_add(
    input logic [CTR_BITS-1:0] a,
    input logic [INC_BITS-1:0] b
  );
`ifdef CACHE_PERF_SATURATE_EN
    logic [SUM_BITS-1:0] s;
    s = {1'b0, a} + SUM_BITS'(b);
    return s[CTR_BITS] ? {CTR_BITS{1'b1}} : s[CTR_BITS-1:0];
`else
    logic [SUM_BITS-1:0] s;
    s = {1'b0, a} + SUM_BITS'(b);
    return s[CTR_BITS-1:0];
`endif
  endfunction

  // Clear drops both the current strobes and the increment already in flight.
  always_comb begin
    inc_d        = '0;
    ctr_d        = ctr_q;
    snap_d       = snap_q;
    snap_valid_d = snap;
    for (int k = 0; k < NUM_EVT; k++) begin
      if (enable && !clear) begin
        inc_d[k] = popcnt(evt[k]);
      end
      if (clear) begin
        ctr_d[k] = '0;
      end else begin
        ctr_d[k] = ctr_add(ctr_q[k], inc_q[k]);
      end
    end
    if (snap) begin
      snap_d = ctr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inc_q        <= '0;
      ctr_q        <= '0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      inc_q        <= inc_d;
      ctr_q        <= ctr_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign ctr_out    = ctr_q;
  assign snap_out   = snap_q;
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_cache_perf_counters.sv
// Bench for cache_perf_counters: a wide (44-bit) and a narrow (4-bit) instance
// share stimulus and are checked every cycle against an event-history model.
module tb_cache_perf_counters;

  localparam int NB   = 4;
  localparam int WW   = 44;
  localparam int SW   = 4;
  localparam int MAXC = 2048;
`ifdef CACHE_PERF_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk, reset, enable, clear, snap;
  logic [NB-1:0] ev [8];

  logic [8*WW-1:0] w_ctr, w_snap;
  logic [8*SW-1:0] s_ctr, s_snap;
  logic            w_sv, s_sv;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit rs [MAXC];
  bit cl [MAXC];
  bit en [MAXC];
  bit sn [MAXC];
  int pop [MAXC][8];

  longint tot [8];

  cache_perf_counters #(.NUM_BANKS(NB), .CTR_BITS(WW)) u_wide (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .snap(snap),
    .evt_reads(ev[0]), .evt_writes(ev[1]),
    .evt_read_misses(ev[2]), .evt_write_misses(ev[3]),
    .evt_bank_stalls(ev[4]), .evt_mshr_stalls(ev[5]),
    .evt_mem_stalls(ev[6]), .evt_crsp_stalls(ev[7]),
    .ctr_out(w_ctr), .snap_out(w_snap), .snap_valid(w_sv)
  );

  cache_perf_counters #(.NUM_BANKS(NB), .CTR_BITS(SW)) u_small (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .snap(snap),
    .evt_reads(ev[0]), .evt_writes(ev[1]),
    .evt_read_misses(ev[2]), .evt_write_misses(ev[3]),
    .evt_bank_stalls(ev[4]), .evt_mshr_stalls(ev[5]),
    .evt_mem_stalls(ev[6]), .evt_crsp_stalls(ev[7]),
    .ctr_out(s_ctr), .snap_out(s_snap), .snap_valid(s_sv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Value seen during cycle c: events from cycles up to c-2 with no
  // clear/reset between the event cycle and cycle c-1 inclusive.
  function automatic longint raw_ctr(int c, int k);
    int z;
    longint s;
    z = -1;
    for (int t = c - 1; t >= 0 && z < 0; t--) begin
      if (rs[t] || cl[t]) z = t;
    end
    s = 0;
    for (int t = z + 1; t <= c - 2; t++) begin
      if (en[t]) s += pop[t][k];
    end
    return s;
  endfunction

  function automatic longint raw_snap(int c, int k);
    for (int t = c - 1; t >= 0; t--) begin
      if (rs[t]) return 0;
      if (sn[t]) return raw_ctr(t, k);
    end
    return 0;
  endfunction

  function automatic longint to_small(longint v);
    if (SAT) return (v > 15) ? 15 : v;
    return v % 16;
  endfunction

  always @(posedge clk) begin
    if (cyc < MAXC) begin
      rs[cyc] <= reset;
      cl[cyc] <= clear;
      en[cyc] <= enable;
      sn[cyc] <= snap;
      for (int k = 0; k < 8; k++) pop[cyc][k] <= $countones(ev[k]);
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("c%0d_wctr%0d", cyc, k),
            longint'(w_ctr[k*WW +: WW]), raw_ctr(cyc, k));
        chk($sformatf("c%0d_wsnap%0d", cyc, k),
            longint'(w_snap[k*WW +: WW]), raw_snap(cyc, k));
        chk($sformatf("c%0d_sctr%0d", cyc, k),
            longint'(s_ctr[k*SW +: SW]), to_small(raw_ctr(cyc, k)));
        chk($sformatf("c%0d_ssnap%0d", cyc, k),
            longint'(s_snap[k*SW +: SW]), to_small(raw_snap(cyc, k)));
      end
      chk($sformatf("c%0d_wsv", cyc), longint'(w_sv),
          longint'(sn[cyc-1] && !rs[cyc-1]));
      chk($sformatf("c%0d_ssv", cyc), longint'(s_sv),
          longint'(sn[cyc-1] && !rs[cyc-1]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic longint wc(int k);
    return longint'(w_ctr[k*WW +: WW]);
  endfunction

  function automatic longint sc(int k);
    return longint'(s_ctr[k*SW +: SW]);
  endfunction

  task automatic set_all(input logic [NB-1:0] v);
    for (int k = 0; k < 8; k++) ev[k] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; snap = 1'b0;
    set_all('0);
    repeat (3) tick();
    reset = 1'b0; enable = 1'b1;
    chk("rst_ctr", longint'(|w_ctr), 0);
    chk("rst_sv", longint'(w_sv), 0);
    tick(); tick();

    // latency: 4'b1011 for one cycle -> 3 two edges later
    ev[0] = 4'b1011;
    tick();
    ev[0] = '0;
    chk("lat_edge1", wc(0), 0);
    tick();
    chk("lat_edge2", wc(0), 3);
    chk("lat_other", wc(1), 0);

    // mshr stalls x5 then enable low with strobes
    ev[5] = 4'b1111;
    repeat (5) tick();
    enable = 1'b0;
    tick();
    chk("mshr_20", wc(5), 20);
    repeat (4) tick();
    ev[5] = '0; enable = 1'b1;
    tick(); tick();
    chk("mshr_hold", wc(5), 20);

    // writes=7 then snap+clear with strobes in the same cycle
    clear = 1'b1; tick(); clear = 1'b0;
    ev[1] = 4'b1111; tick();
    ev[1] = 4'b0111; tick();
    ev[1] = '0; tick(); tick();
    chk("wr_7", wc(1), 7);
    snap = 1'b1; clear = 1'b1; ev[1] = 4'b1111;
    tick();
    snap = 1'b0; clear = 1'b0; ev[1] = '0;
    chk("sc_sv1", longint'(w_sv), 1);
    chk("sc_snap7", longint'(w_snap[1*WW +: WW]), 7);
    chk("sc_ctr0", wc(1), 0);
    tick();
    chk("sc_sv0", longint'(w_sv), 0);
    tick();
    chk("sc_drop", wc(1), 0);

    // narrow instance: 20 read events
    clear = 1'b1; tick(); clear = 1'b0;
    ev[0] = 4'b1111;
    repeat (5) tick();
    ev[0] = '0;
    tick(); tick();
    chk("small_20", sc(0), SAT ? 15 : 4);
    ev[0] = 4'b1111;
    repeat (3) tick();
    ev[0] = '0;
    tick(); tick();
    chk("small_32", sc(0), SAT ? 15 : 0);
    chk("wide_32", wc(0), 32);

    // reset mid-stream overriding a snap
    set_all(4'b1111);
    repeat (3) tick();
    snap = 1'b1; reset = 1'b1;
    tick();
    snap = 1'b0; reset = 1'b0;
    chk("mrst_ctr", longint'(|w_ctr), 0);
    chk("mrst_snap", longint'(|w_snap), 0);
    chk("mrst_sv", longint'(w_sv), 0);
    tick();
    chk("mrst_r1", wc(0), 0);
    tick();
    chk("mrst_r2", wc(0), 4);
    set_all('0);
    tick(); tick();

    // random strobes and snaps
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < 8; k++) tot[k] = 0;
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 8; k++) begin
        ev[k] = NB'($urandom_range(0, 15));
        tot[k] += $countones(ev[k]);
      end
      snap = ($urandom_range(0, 7) == 0);
      tick();
    end
    set_all('0); snap = 1'b0;
    tick(); tick();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("final%0d", k), wc(k), tot[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
